// File: rtl/nco_phase_acc_pkg.sv
// Shared phase constants (Q3.21 radians) and FSM state type for the NCO.
package nco_phase_acc_pkg;

    localparam int PHASE_W = 24;

    localparam logic [PHASE_W-1:0] TWO_PI          = 24'hC90FDB;
    localparam logic [PHASE_W-1:0] PI              = 24'h6487ED;
    localparam logic [PHASE_W-1:0] PI_OVER_2       = 24'h3243F7;
    localparam logic [PHASE_W-1:0] THREE_PI_OVER_2 = 24'h96CBE4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_e;

endpackage

// File: rtl/nco_phase_acc_mod2pi_add.sv
// Combinational modular adder: y = (a + b) mod TWO_PI_C, both operands < TWO_PI_C.
module mod2pi_add
    import nco_phase_acc_pkg::*;
#(
    parameter int                 W        = PHASE_W,
    parameter logic [W-1:0]       TWO_PI_C = TWO_PI
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] y_o
);

    logic [W:0]   sum;
    logic [W-1:0] sum_red;

    // A single conditional subtraction is enough since a + b < 2 * TWO_PI_C.
    always_comb begin
        sum     = {1'b0, a_i} + {1'b0, b_i};
        // The true reduced value fits in W bits, so low-bit subtraction is exact.
        sum_red = sum[W-1:0] - TWO_PI_C;
        y_o     = (sum >= {1'b0, TWO_PI_C}) ? sum_red : sum[W-1:0];
    end

endmodule

// File: rtl/nco_phase_acc.sv
// Phase accumulator feeding the sine core: acc += ftw on each tick,
// theta = (acc + poff) mod 2*pi one edge later, with valid/ready output.
//
//   state | meaning
//   IDLE  | en_i low: ticks ignored, acc holds, pending output still offered
//   RUN   | ticks advance acc and schedule a new theta
//   STALL | output held (valid & !ready): ticks advance acc, set overrun
//
// The state is decoded each cycle from en_i and the output handshake; all
// memory of it lives in theta_valid_q, so no separate state flop is kept.
module nco_phase_acc
    import nco_phase_acc_pkg::*;
#(
    parameter int                   PHASE_W  = nco_phase_acc_pkg::PHASE_W,
    parameter logic [PHASE_W-1:0]   TWO_PI_C = TWO_PI
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_i,
    input  logic               tick_i,
    input  logic [PHASE_W-1:0] ftw_i,
    input  logic               ftw_we_i,
    input  logic [PHASE_W-1:0] poff_i,
    input  logic               poff_we_i,
    input  logic               sync_i,
    output logic [PHASE_W-1:0] theta_o,
    output logic               theta_valid_o,
    input  logic               theta_ready_i,
    output logic               overrun_o,
    input  logic               ovr_clr_i
);

    logic [PHASE_W-1:0] acc_q, acc_d;
    logic [PHASE_W-1:0] ftw_q, ftw_d;
    logic [PHASE_W-1:0] poff_q, poff_d;
    logic [PHASE_W-1:0] theta_q, theta_d;
    logic               theta_valid_q, theta_valid_d;
    logic               overrun_q, overrun_d;
    logic               sync_pend_q, sync_pend_d;
    logic               stg2_pend_q, stg2_pend_d;

    logic [PHASE_W-1:0] acc_sum, theta_sum, ftw_red, poff_red;
    logic               stall;
    logic               tick_acc;
    logic               ovr_set;
    state_e             state_c;

    mod2pi_add #(.W(PHASE_W), .TWO_PI_C(TWO_PI_C)) u_add_stg1 (
        .a_i(acc_q), .b_i(ftw_q), .y_o(acc_sum)
    );
    mod2pi_add #(.W(PHASE_W), .TWO_PI_C(TWO_PI_C)) u_add_stg2 (
        .a_i(acc_q), .b_i(poff_q), .y_o(theta_sum)
    );
    mod2pi_add #(.W(PHASE_W), .TWO_PI_C(TWO_PI_C)) u_red_ftw (
        .a_i(ftw_i), .b_i('0), .y_o(ftw_red)
    );
    mod2pi_add #(.W(PHASE_W), .TWO_PI_C(TWO_PI_C)) u_red_poff (
        .a_i(poff_i), .b_i('0), .y_o(poff_red)
    );

    // Decode the operating state from enable and the output handshake.
    always_comb begin
        stall   = theta_valid_q && !theta_ready_i;
        state_c = IDLE;
        if (en_i) begin
            state_c = stall ? STALL : RUN;
        end
        tick_acc = tick_i && (state_c != IDLE);
    end

    // Next-state logic for the accumulator, output stage and status.
    always_comb begin
        acc_d         = acc_q;
        ftw_d         = ftw_we_i  ? ftw_red  : ftw_q;
        poff_d        = poff_we_i ? poff_red : poff_q;
        theta_d       = theta_q;
        theta_valid_d = stall;
        sync_pend_d   = sync_pend_q | sync_i;
        stg2_pend_d   = 1'b0;
        ovr_set       = 1'b0;

        // Stage 1: advance (or restart) the phase on an accepted tick.
        if (tick_acc) begin
            acc_d       = (sync_i || sync_pend_q) ? '0 : acc_sum;
            sync_pend_d = 1'b0;
            if (state_c == STALL) begin
                ovr_set = 1'b1;
            end else begin
                stg2_pend_d = 1'b1;
            end
        end

        // Stage 2: publish acc + poff unless the held output is still stalled.
        if (stg2_pend_q) begin
            if (stall) begin
                ovr_set = 1'b1;
            end else begin
                theta_d       = theta_sum;
                theta_valid_d = 1'b1;
            end
        end

        if (ovr_set) begin
            overrun_d = 1'b1;
        end else if (ovr_clr_i) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q         <= '0;
            ftw_q         <= '0;
            poff_q        <= '0;
            theta_q       <= '0;
            theta_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
            sync_pend_q   <= 1'b0;
            stg2_pend_q   <= 1'b0;
        end else begin
            acc_q         <= acc_d;
            ftw_q         <= ftw_d;
            poff_q        <= poff_d;
            theta_q       <= theta_d;
            theta_valid_q <= theta_valid_d;
            overrun_q     <= overrun_d;
            sync_pend_q   <= sync_pend_d;
            stg2_pend_q   <= stg2_pend_d;
        end
    end

    assign theta_o       = theta_q;
    assign theta_valid_o = theta_valid_q;
    assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_nco_phase_acc.sv
// Directed + randomized bench for nco_phase_acc against an arithmetic phase model.
module tb_nco_phase_acc;

    localparam int unsigned TP = 32'hC90FDB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en_i = 1'b0;
    logic        tick_i = 1'b0;
    logic [23:0] ftw_i = '0;
    logic        ftw_we_i = 1'b0;
    logic [23:0] poff_i = '0;
    logic        poff_we_i = 1'b0;
    logic        sync_i = 1'b0;
    logic [23:0] theta_o;
    logic        theta_valid_o;
    logic        theta_ready_i = 1'b1;
    logic        overrun_o;
    logic        ovr_clr_i = 1'b0;

    int passed = 0;
    int total  = 0;

    // Reference model: phase in radians*2^21, reduced with plain modulo.
    int unsigned acc_m, ftw_m, poff_m, exp_theta;
    bit          sync_pend_m;

    nco_phase_acc dut (
        .clk(clk), .rst(rst), .en_i(en_i), .tick_i(tick_i),
        .ftw_i(ftw_i), .ftw_we_i(ftw_we_i), .poff_i(poff_i), .poff_we_i(poff_we_i),
        .sync_i(sync_i), .theta_o(theta_o), .theta_valid_o(theta_valid_o),
        .theta_ready_i(theta_ready_i), .overrun_o(overrun_o), .ovr_clr_i(ovr_clr_i)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_reset();
        acc_m = 0; ftw_m = 0; poff_m = 0; exp_theta = 0; sync_pend_m = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic load_ftw(input int unsigned v);
        ftw_i = v[23:0]; ftw_we_i = 1'b1;
        step();
        ftw_we_i = 1'b0;
        ftw_m = v % TP;
    endtask

    task automatic load_poff(input int unsigned v);
        poff_i = v[23:0]; poff_we_i = 1'b1;
        step();
        poff_we_i = 1'b0;
        poff_m = v % TP;
    endtask

    // One-cycle tick; the model advances with the ftw in force before this edge.
    task automatic tick_only(input bit s);
        sync_i = s;
        tick_i = 1'b1;
        if (en_i) begin
            if (s || sync_pend_m) acc_m = 0;
            else                  acc_m = (acc_m + ftw_m) % TP;
            sync_pend_m = 0;
            exp_theta   = (acc_m + poff_m) % TP;
        end else if (s) begin
            sync_pend_m = 1;
        end
        step();
        tick_i = 1'b0;
        sync_i = 1'b0;
    endtask

    // Wait (bounded) for valid, compare theta, then let one handshake edge pass.
    task automatic expect_out(input string tag, input int unsigned exp);
        int n = 0;
        while (!theta_valid_o && n < 6) begin
            step();
            n++;
        end
        chk({tag, "_valid"}, {31'd0, theta_valid_o}, 32'd1);
        chk(tag, {8'd0, theta_o}, exp);
        step();
    endtask

    initial begin
        int unsigned first_theta;
        bit          seen_valid;

        model_reset();
        step();
        step();
        chk("rst_theta", {8'd0, theta_o}, 32'd0);
        chk("rst_valid", {31'd0, theta_valid_o}, 32'd0);
        chk("rst_ovr",   {31'd0, overrun_o}, 32'd0);
        rst = 1'b0;

        // Wrap through 2*pi in quarter turns.
        load_ftw(32'h3243F7);
        en_i = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            tick_only(1'b0);
            expect_out("wrap", exp_theta);
        end
        chk("wrap_last_abs", {8'd0, theta_o}, 32'h000001);

        // Offset that lands exactly on 2*pi.
        do_reset();
        load_poff(32'h6487ED);
        load_ftw(32'h3243F7);
        tick_only(1'b0);
        expect_out("off1", 32'h96CBE4);
        tick_only(1'b0);
        expect_out("off2", 32'h000000);

        // Load reduction.
        do_reset();
        load_ftw(32'hD00000);
        tick_only(1'b0);
        expect_out("ldred", 32'h06F025);

        // Backpressure: output held, ticks still advance acc, overrun sticks.
        theta_ready_i = 1'b0;
        tick_only(1'b0);
        expect_out("bp_first", exp_theta);
        first_theta = exp_theta;
        for (int i = 0; i < 3; i++) begin
            tick_only(1'b0);
            step();
            chk("bp_hold", {8'd0, theta_o}, first_theta);
            chk("bp_hold_valid", {31'd0, theta_valid_o}, 32'd1);
        end
        chk("bp_ovr", {31'd0, overrun_o}, 32'd1);
        theta_ready_i = 1'b1;
        step();
        chk("bp_drop_valid", {31'd0, theta_valid_o}, 32'd0);
        tick_only(1'b0);
        expect_out("bp_resume", exp_theta);
        ovr_clr_i = 1'b1;
        step();
        ovr_clr_i = 1'b0;
        chk("ovr_clr", {31'd0, overrun_o}, 32'd0);

        // Set beats clear when both land together.
        theta_ready_i = 1'b0;
        tick_only(1'b0);
        expect_out("sw_first", exp_theta);
        ovr_clr_i = 1'b1;
        tick_only(1'b0);
        ovr_clr_i = 1'b0;
        chk("set_wins", {31'd0, overrun_o}, 32'd1);
        theta_ready_i = 1'b1;
        step();
        ovr_clr_i = 1'b1;
        step();
        ovr_clr_i = 1'b0;

        // Randomized ticks, loads (incl. ftw load with tick) and syncs.
        for (int i = 0; i < 24; i++) begin
            int unsigned nf;
            bit          we;
            if ($urandom_range(0, 3) == 0) load_poff($urandom_range(0, 32'hFFFFFF));
            nf = $urandom_range(0, 32'hFFFFFF);
            we = ($urandom_range(0, 3) == 0);
            ftw_i = nf[23:0];
            ftw_we_i = we;
            tick_only($urandom_range(0, 7) == 0);
            ftw_we_i = 1'b0;
            if (we) ftw_m = nf % TP;
            expect_out("rand", exp_theta);
            for (int g = $urandom_range(0, 2); g > 0; g--) step();
        end

        // Back-to-back ticks through the stage-2 pipeline.
        load_ftw(32'h123456);
        tick_only(1'b0);
        first_theta = exp_theta;
        tick_only(1'b0);
        chk("b2b_1", {8'd0, theta_o}, first_theta);
        step();
        chk("b2b_2", {8'd0, theta_o}, exp_theta);
        step();

        // Sync alone is held until the next tick, which restarts the phase.
        load_poff(32'h0ABCDE);
        tick_only(1'b0);
        expect_out("pre_sync", exp_theta);
        sync_i = 1'b1;
        sync_pend_m = 1;
        step();
        sync_i = 1'b0;
        step();
        tick_only(1'b0);
        expect_out("sync", 32'h0ABCDE);

        // FTW = 0 gives a constant phase equal to poff.
        load_ftw(32'h0);
        tick_only(1'b0);
        expect_out("ftw0_a", poff_m);
        tick_only(1'b0);
        expect_out("ftw0_b", poff_m);

        // Disabled: ticks ignored, acc unchanged.
        load_ftw(32'h200000);
        en_i = 1'b0;
        seen_valid = 0;
        for (int i = 0; i < 3; i++) begin
            tick_only(1'b0);
            step();
            if (theta_valid_o) seen_valid = 1;
            step();
            if (theta_valid_o) seen_valid = 1;
        end
        chk("en0_no_valid", {31'd0, seen_valid}, 32'd0);
        en_i = 1'b1;
        tick_only(1'b0);
        expect_out("en_resume", exp_theta);

        // Reset while stalled drops everything.
        theta_ready_i = 1'b0;
        tick_only(1'b0);
        expect_out("rs_first", exp_theta);
        tick_only(1'b0);
        chk("rs_ovr_set", {31'd0, overrun_o}, 32'd1);
        rst = 1'b1;
        step();
        chk("rs_valid", {31'd0, theta_valid_o}, 32'd0);
        chk("rs_theta", {8'd0, theta_o}, 32'd0);
        chk("rs_ovr",   {31'd0, overrun_o}, 32'd0);
        rst = 1'b0;
        theta_ready_i = 1'b1;
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
